// File: rtl/sfp_pkg.sv
// sfp_pkg: shared definitions for the SFP row sequencer.
//   - default lane count and data widths of the SFP stage
//   - default phase lengths for the acc / div / wait phases
//   - FSM state encoding used by sfp_seq
package sfp_pkg;

  localparam int COL       = 8;
  localparam int BW        = 8;
  localparam int BW_PSUM   = 2*BW + 3;
  localparam int OUT_SHIFT = 8;
  localparam int BW_OUT    = OUT_SHIFT + 1;

  localparam int ACC_CYC   = 2;
  localparam int DIV_CYC   = 2;
  localparam int WAIT_CYC  = 2;

  // Width of the shared phase counter; must hold max(phase length)-1.
  localparam int CTR_W     = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_LOAD,
    S_ACC,
    S_GAP,
    S_DIV,
    S_WAIT,
    S_WR,
    S_DONE
  } sfp_state_e;

endpackage

// File: rtl/sfp_seq_ctr.sv
// sfp_seq_ctr: down-counter timing the multi-cycle phases of sfp_seq.
//   clk, reset  : clock, synchronous active-high reset
//   load_i      : load load_val_i this edge (wins over decrement)
//   load_val_i  : phase length minus one
//   zero_o      : count has reached zero (last cycle of the phase)
// The count sticks at zero between phases, so it never needs disabling.
module sfp_seq_ctr
  import sfp_pkg::*;
#(
  parameter int W = CTR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)              cnt_q <= '0;
    else if (load_i)        cnt_q <= load_val_i;
    else if (cnt_q != '0)   cnt_q <= cnt_q - W'(1);
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sfp_seq.sv
// sfp_seq: row sequencer for the SFP normalization stage.
// Per row: read psum SRAM (RD), register the row into sfp_in (LOAD),
// hold acc (ACC), one idle cycle (GAP), hold div (DIV), let sfp_row
// settle (WAIT), then write sfp_out to the output SRAM (WR).
//   clk, reset           : clock, synchronous active-high reset
//   start                : launch request, sampled only in IDLE
//   num_rows/psum_base/out_base : job descriptor, latched at start
//   busy, done           : job status (done is a one-cycle pulse)
//   psum_cen/psum_a/psum_q       : psum SRAM read port (1-cycle latency)
//   acc, div, sfp_in, sfp_out    : sfp_row row protocol
//   out_cen/out_wen/out_a/out_d  : output SRAM write port
module sfp_seq
  import sfp_pkg::*;
#(
  parameter int col       = COL,
  parameter int bw        = BW,
  parameter int bw_psum   = 2*bw + 3,
  parameter int out_shift = OUT_SHIFT,
  parameter int bw_out    = out_shift + 1,
  parameter int addr_w    = 4,
  parameter int acc_cyc   = ACC_CYC,
  parameter int div_cyc   = DIV_CYC,
  parameter int wait_cyc  = WAIT_CYC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [addr_w:0]         num_rows,
  input  logic [addr_w-1:0]       psum_base,
  input  logic [addr_w-1:0]       out_base,
  output logic                    busy,
  output logic                    done,
  output logic                    psum_cen,
  output logic [addr_w-1:0]       psum_a,
  input  logic [col*bw_psum-1:0]  psum_q,
  output logic                    acc,
  output logic                    div,
  output logic [col*bw_psum-1:0]  sfp_in,
  input  logic [col*bw_out-1:0]   sfp_out,
  output logic                    out_cen,
  output logic                    out_wen,
  output logic [addr_w-1:0]       out_a,
  output logic [col*bw_out-1:0]   out_d
);

  sfp_state_e              state_q;
  logic [addr_w:0]         num_q, row_q, row_nxt;
  logic [addr_w-1:0]       pbase_q, obase_q;
  logic                    busy_q, done_q, acc_q, div_q;
  logic                    psum_cen_q, out_cen_q, out_wen_q;
  logic [addr_w-1:0]       psum_a_q, out_a_q;
  logic [col*bw_psum-1:0]  sfp_in_q;

  logic                    ctr_load, ctr_zero;
  logic [CTR_W-1:0]        ctr_val;

  assign row_nxt = row_q + (addr_w+1)'(1);

  // Each phase counter load happens on the edge that enters the phase.
  always_comb begin
    ctr_load = 1'b0;
    ctr_val  = '0;
    unique case (state_q)
      S_LOAD:  begin ctr_load = 1'b1; ctr_val = CTR_W'(acc_cyc - 1); end
      S_GAP:   begin ctr_load = 1'b1; ctr_val = CTR_W'(div_cyc - 1); end
      S_DIV:   begin ctr_load = ctr_zero; ctr_val = CTR_W'(wait_cyc - 1); end
      default: ;
    endcase
  end

  sfp_seq_ctr #(.W(CTR_W)) u_ctr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ctr_load),
    .load_val_i (ctr_val),
    .zero_o     (ctr_zero)
  );

  // Outputs are registered for the state being entered, so each strobe
  // is high exactly in the cycles its state occupies.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      row_q      <= '0;
      pbase_q    <= '0;
      obase_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_q      <= 1'b0;
      div_q      <= 1'b0;
      psum_cen_q <= 1'b1;
      out_cen_q  <= 1'b1;
      out_wen_q  <= 1'b1;
      psum_a_q   <= '0;
      out_a_q    <= '0;
      sfp_in_q   <= '0;
    end else begin
      done_q     <= 1'b0;
      acc_q      <= 1'b0;
      div_q      <= 1'b0;
      psum_cen_q <= 1'b1;
      out_cen_q  <= 1'b1;
      out_wen_q  <= 1'b1;
      unique case (state_q)
        S_IDLE: if (start) begin
          num_q   <= num_rows;
          pbase_q <= psum_base;
          obase_q <= out_base;
          row_q   <= '0;
          if (num_rows == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= S_RD;
            busy_q     <= 1'b1;
            psum_cen_q <= 1'b0;
            psum_a_q   <= psum_base;
          end
        end
        S_RD:   state_q <= S_LOAD;
        S_LOAD: begin
          sfp_in_q <= psum_q;
          state_q  <= S_ACC;
          acc_q    <= 1'b1;
        end
        S_ACC:  if (ctr_zero) state_q <= S_GAP;
                else          acc_q   <= 1'b1;
        S_GAP:  begin
          state_q <= S_DIV;
          div_q   <= 1'b1;
        end
        S_DIV:  if (ctr_zero) state_q <= S_WAIT;
                else          div_q   <= 1'b1;
        S_WAIT: if (ctr_zero) begin
          state_q   <= S_WR;
          out_cen_q <= 1'b0;
          out_wen_q <= 1'b0;
          out_a_q   <= obase_q + row_q[addr_w-1:0];
        end
        S_WR: begin
          if (row_nxt == num_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            row_q      <= row_nxt;
            state_q    <= S_RD;
            psum_cen_q <= 1'b0;
            psum_a_q   <= pbase_q + row_nxt[addr_w-1:0];
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign acc      = acc_q;
  assign div      = div_q;
  assign psum_cen = psum_cen_q;
  assign psum_a   = psum_a_q;
  assign sfp_in   = sfp_in_q;
  assign out_cen  = out_cen_q;
  assign out_wen  = out_wen_q;
  assign out_a    = out_a_q;
  // sfp_out must be the value present during WR, so the write data is a
  // gated pass-through rather than a register; zero whenever not writing.
  assign out_d    = out_wen_q ? '0 : sfp_out;

endmodule

// File: tb/tb_sfp_seq.sv
// tb_sfp_seq: self-checking bench for sfp_seq with SRAM models and a
// behavioural stand-in for sfp_row (normalizes the row latched on div).
module tb_sfp_seq;
  import sfp_pkg::*;

  localparam int AW = 4;
  localparam int PW = COL*BW_PSUM;
  localparam int OW = COL*BW_OUT;
  localparam int R  = 1 + 1 + ACC_CYC + 1 + DIV_CYC + WAIT_CYC + 1;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW:0]   num_rows;
  logic [AW-1:0] psum_base, out_base;
  logic          busy, done, psum_cen, acc, div, out_cen, out_wen;
  logic [AW-1:0] psum_a, out_a;
  logic [PW-1:0] psum_q = '0;
  logic [PW-1:0] sfp_in;
  logic [OW-1:0] sfp_out;
  logic [OW-1:0] out_d;

  int n_chk = 0;
  int n_fail = 0;

  sfp_seq dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .psum_base(psum_base), .out_base(out_base), .busy(busy), .done(done),
    .psum_cen(psum_cen), .psum_a(psum_a), .psum_q(psum_q), .acc(acc),
    .div(div), .sfp_in(sfp_in), .sfp_out(sfp_out), .out_cen(out_cen),
    .out_wen(out_wen), .out_a(out_a), .out_d(out_d)
  );

  always #5 clk = ~clk;

  // Golden normalization: out = (|x| << OUT_SHIFT) / sum|x|
  function automatic logic [OW-1:0] norm(input logic [PW-1:0] row);
    longint a [COL];
    longint s;
    logic signed [BW_PSUM-1:0] x;
    logic [OW-1:0] r;
    s = 0;
    r = '0;
    for (int c = 0; c < COL; c++) begin
      x = row[c*BW_PSUM +: BW_PSUM];
      a[c] = (x < 0) ? -longint'(x) : longint'(x);
      s += a[c];
    end
    for (int c = 0; c < COL; c++)
      r[c*BW_OUT +: BW_OUT] = (s == 0) ? '0 : BW_OUT'((a[c] << OUT_SHIFT) / s);
    return r;
  endfunction

  // psum SRAM: one-cycle read latency
  logic [PW-1:0] mem [16];
  always @(posedge clk) if (!psum_cen) psum_q <= mem[psum_a];

  // sfp_row stand-in: result becomes valid once div has been seen
  logic [OW-1:0] res = '0;
  always @(posedge clk) if (div) res <= norm(sfp_in);
  assign sfp_out = res;

  // output SRAM write log
  typedef struct { logic [AW-1:0] a; logic [OW-1:0] d; } wr_t;
  wr_t wlog [$];
  always @(negedge clk) begin
    wr_t w;
    if (!out_cen && !out_wen) begin
      w.a = out_a;
      w.d = out_d;
      wlog.push_back(w);
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++)
      for (int c = 0; c < COL; c++)
        mem[i][c*BW_PSUM +: BW_PSUM] = BW_PSUM'($urandom);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk(nm, {busy, done, acc, div, psum_cen, out_cen, out_wen, psum_a, out_a},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0});
    chk({nm, "_data"}, {sfp_in, out_d}, '0);
  endtask

  // Runs one job from an IDLE cycle; checks every cycle against the row
  // timeline (RD, LOAD, ACC.., GAP, DIV.., WAIT.., WR) and the write log.
  task automatic run_job(input int n, input int pb, input int ob, input int s2,
                         input int rst_at, input int exp_done, input int exp_wr);
    int tend, done_at, off, k;
    logic busy_e, wr_e;
    logic [6:0] ctl_e;
    @(negedge clk);
    wlog.delete();
    num_rows  = n[AW:0];
    psum_base = pb[AW-1:0];
    out_base  = ob[AW-1:0];
    start     = 1'b1;
    tend      = (rst_at > 0) ? rst_at : n*R + 1;
    done_at   = -1;
    for (int t = 1; t <= tend; t++) begin
      @(negedge clk);
      start  = (t == s2);
      busy_e = (t <= n*R);
      off    = (t - 1) % R;
      k      = (t - 1) / R;
      wr_e   = busy_e && off == R-1;
      ctl_e  = {busy_e, t == n*R + 1, !(busy_e && off == 0),
                busy_e && off >= 2 && off < 2 + ACC_CYC,
                busy_e && off >= 3 + ACC_CYC && off < 3 + ACC_CYC + DIV_CYC,
                !wr_e, !wr_e};
      chk("ctl", {busy, done, psum_cen, acc, div, out_cen, out_wen}, ctl_e);
      if (busy_e && off == 0) chk("psum_a", psum_a, (pb + k) % 16);
      if (busy_e && off >= 2) chk("sfp_in_hold", sfp_in, mem[(pb + k) % 16]);
      if (wr_e)               chk("out_a", out_a, (ob + k) % 16);
      if (done && done_at < 0) done_at = t;
    end
    start = 1'b0;
    if (rst_at > 0) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_reset_vals("midrow_reset");
    end else begin
      chk("done_cycle", done_at, exp_done);
    end
    chk("n_writes", wlog.size(), exp_wr);
    for (int i = 0; i < wlog.size() && i < exp_wr; i++) begin
      chk("wr_addr", wlog[i].a, (ob + i) % 16);
      chk("wr_data", wlog[i].d, norm(mem[(pb + i) % 16]));
    end
  endtask

  typedef struct {
    int n, pb, ob, s2, rst, fixed, exp_done, exp_wr;
  } vec_t;

  initial begin
    vec_t tbl [7];
    logic [PW-1:0] row1;
    int rn, rpb, rob;

    tbl[0] = '{1,  0,  6,  0,  0, 1, 11, 1};  // single known row
    tbl[1] = '{8,  3,  5,  0,  0, 0, 81, 8};  // eight rows
    tbl[2] = '{4, 14, 15,  0,  0, 0, 41, 4};  // address wrap
    tbl[3] = '{0,  2,  3,  0,  0, 0,  1, 0};  // zero rows
    tbl[4] = '{8,  3,  5, 20,  0, 0, 81, 8};  // start while busy
    tbl[5] = '{8,  1,  9,  0, 26, 0, -1, 2};  // reset in row 2 DIV
    tbl[6] = '{3,  7,  2,  0,  0, 0, 31, 3};  // fresh job after reset

    row1 = '0;
    row1[0*BW_PSUM +: BW_PSUM] = 19'sd100;
    row1[1*BW_PSUM +: BW_PSUM] = -19'sd50;
    row1[2*BW_PSUM +: BW_PSUM] = 19'sd25;

    reset = 1'b1; start = 1'b0; num_rows = '0; psum_base = '0; out_base = '0;
    fill_mem();
    repeat (3) @(negedge clk);
    chk_reset_vals("reset_state");
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      fill_mem();
      if (tbl[i].fixed != 0) mem[tbl[i].pb] = row1;
      run_job(tbl[i].n, tbl[i].pb, tbl[i].ob, tbl[i].s2, tbl[i].rst,
              tbl[i].exp_done, tbl[i].exp_wr);
    end

    // back-to-back: second start lands in the IDLE cycle right after done
    fill_mem();
    run_job(1, 4, 4, 0, 0, 11, 1);
    run_job(2, 6, 8, 0, 0, 21, 2);

    // reset together with start must win
    @(negedge clk);
    reset = 1'b1; start = 1'b1; num_rows = 5'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("reset_vs_start", {busy, psum_cen}, 2'b01);
    @(negedge clk);
    chk("reset_vs_start_idle", {busy, psum_cen, done}, 3'b010);

    // randomized jobs, last one longer than the SRAM depth
    for (int j = 0; j < 5; j++) begin
      rn  = (j == 4) ? 20 : int'($urandom_range(1, 6));
      rpb = int'($urandom_range(0, 15));
      rob = int'($urandom_range(0, 15));
      fill_mem();
      run_job(rn, rpb, rob, 0, 0, rn*R + 1, rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sfp_seq.md
# sfp_seq

Row sequencer for the SFP normalization stage. It reads psum rows from the psum SRAM and drives `sfp_row` through its row protocol: hold `sfp_in`, pulse `acc`, then pulse `div`. It captures each normalized `sfp_out` row and writes it to the output SRAM. It replaces the hand-driven stimulus currently used to exercise `sfp_row` and sits between the psum SRAM and the output SRAM in the core.

## Interface

**Parameters**
- `col`, 8: lanes per row
- `bw`, 8: activation/weight width
- `bw_psum`, 2*bw+3: psum lane width (19)
- `out_shift`, 8: fractional bits of the normalized output
- `bw_out`, out_shift+1: output lane width (9)
- `addr_w`, 4: SRAM address width
- `acc_cyc`, 2: cycles `acc` is held high
- `div_cyc`, 2: cycles `div` is held high
- `wait_cyc`, 2: cycles from `div` deassert to `sfp_out` capture

**Ports**
- `clk`  in  1: single clock; everything is on the rising edge
- `reset`  in  1: synchronous, active-high
- `start`  in  1: one-cycle launch request; sampled only in IDLE
- `num_rows`  in  addr_w+1: number of rows to process, latched at `start`
- `psum_base`  in  addr_w: first psum SRAM row, latched at `start`
- `out_base`  in  addr_w: first output SRAM row, latched at `start`
- `busy`  out  1: high from the cycle after an accepted `start` until `done`
- `done`  out  1: one-cycle pulse when the job is complete
- `psum_cen`  out  1: psum SRAM chip enable, active-low, read-only port
- `psum_a`  out  addr_w: psum SRAM address
- `psum_q`  in  col*bw_psum: psum SRAM read data, valid 1 cycle after the read
- `acc`  out  1: to `sfp_row`
- `div`  out  1: to `sfp_row`
- `sfp_in`  out  col*bw_psum: registered row to `sfp_row`; lane c is at bits [c*bw_psum +: bw_psum]
- `sfp_out`  in  col*bw_out: normalized row from `sfp_row`; signed lanes, same lane order
- `out_cen`  out  1: output SRAM chip enable, active-low
- `out_wen`  out  1: output SRAM write enable, active-low
- `out_a`  out  addr_w: output SRAM address
- `out_d`  out  col*bw_out: output SRAM write data

## Operation

**FSM states:** IDLE, RD, LOAD, ACC, GAP, DIV, WAIT, WR, DONE.

- **IDLE:** on `start`, latch `num_rows`, `psum_base` and `out_base`. Clear the row counter. Go to RD, or to DONE if `num_rows`==0.
- **RD (1 cycle):** `psum_cen`=0, `psum_a`=psum_base+row.
- **LOAD (1 cycle):** register `psum_q` into `sfp_in`. `sfp_in` holds that value until the next LOAD.
- **ACC (acc_cyc cycles):** `acc`=1.
- **GAP (1 cycle):** `acc`=0, `div`=0.
- **DIV (div_cyc cycles):** `div`=1.
- **WAIT (wait_cyc cycles):** `div`=0.
- **WR (1 cycle):** `out_cen`=0, `out_wen`=0, `out_a`=out_base+row, `out_d`=`sfp_out` sampled this cycle.
  - If row+1==num_rows, go to DONE.
  - Otherwise increment row and go to RD.
- **DONE (1 cycle):** `done`=1, `busy`=0, then go to IDLE.

**Addressing:** both address sums are modulo 2^addr_w, so rows wrap past the top of the SRAM. `num_rows` above 2^addr_w is legal and simply overwrites rows.

**Data handling:** no arithmetic is done on the data path. Lanes pass through unchanged and in order.

**Unused `sfp_row` ports:** this block does not drive `sum_in` or `fifo_ext_rd`. At integration `sum_in` is tied to 0 and `fifo_ext_rd` to 0.

**`start` while busy:** ignored, with no effect on the running job.

**`acc`/`div` overlap:** the two are never high in the same cycle.

**Reset:**
- Any cycle with `reset`=1 forces IDLE at the next edge, including mid-row. A partially processed row is abandoned and its output is not written.
- Reset values: `busy`=0, `done`=0, `acc`=0, `div`=0, `psum_cen`=1, `out_cen`=1, `out_wen`=1, `psum_a`=0, `out_a`=0, `sfp_in`=0, `out_d`=0.
- `reset` together with `start` gives reset.
- `sfp_row` sums are rebuilt each row from `acc`, so a mid-row reset needs no clearing beyond `sfp_row`'s own reset.

## Timing

- **Cycles per row:** R = 1+1+acc_cyc+1+div_cyc+wait_cyc+1, which is 10 with the defaults.
- **Job timeline:**
  - `start` sampled at edge 0.
  - `busy` goes high after edge 0.
  - The first `psum_cen` low is the cycle after edge 0.
  - The final WR is in cycle N·R.
  - `done` is high in cycle N·R+1, and `busy` drops in that same cycle.
- **`num_rows`==0:** `done` in cycle 1. No SRAM access and no `acc`/`div` activity.
- **Next job:** `start` is accepted again in the cycle after `done`.
- **Hold of `sfp_in`:** `sfp_in` is stable from the end of LOAD through WR, covering every `acc` and `div` cycle.
- **`sfp_out` capture:** `sfp_out` is sampled in WR, wait_cyc cycles after the last `div` cycle, and written to SRAM at the same edge.

## Structure

- **Shared package `sfp_pkg`:**
  - Parameter defaults: `col`, `bw`, `bw_psum`, `out_shift`, `bw_out`.
  - FSM state encoding.
  - The default cycle counts (`acc_cyc`, `div_cyc`, `wait_cyc`).
- **Sub-module `sfp_seq_ctr`:** the phase counter (load value, decrement, zero flag), reused for the ACC, DIV and WAIT phases.
- **Top module:** holds the FSM, row counter, address adders and data registers.

## Test plan

Each scenario uses a real `sfp_row`, SRAM models and a golden model: per row, sum_abs = Σ|x|, and out = (|x|<<out_shift)/sum_abs.

- **Single row:** `num_rows`=1, `psum_base`=0, row {100,-50,25,0,…}. Require exactly one write to `out_a`=`out_base`, `out_d` equal to golden, `done` at cycle 11, and `acc` and `div` each high for 2 cycles with 1 gap cycle.
- **Eight rows:** `num_rows`=8, `psum_base`=3, `out_base`=5, random signed 19-bit lanes. Require writes to rows 5..12 in order, all equal to golden, `done` at cycle 81, and `busy` high for cycles 1..80.
- **Wrap-around:** `psum_base`=14, `out_base`=15, `num_rows`=4. Require reads from 14,15,0,1 and writes to 15,0,1,2.
- **Zero rows and start while busy:** `num_rows`=0 gives `done` at cycle 1 with no `cen` activity. A second `start` at cycle 20 of an 8-row job causes no change in the write sequence or `done` timing.
- **Reset mid-row:** assert `reset` during DIV of row 2. At the next edge all outputs take their reset values. Row 2 is never written. A fresh `start` afterwards completes correctly.
- **Back-to-back jobs:** `start` in the cycle after `done`. The second job begins its RD on the following cycle, with no gap beyond IDLE.
